mp_linefill: RTL and testbench

Memory-side line filler that serves the data cache's miss and write-back requests. It accepts one 128-bit cache-line transaction at a time from the cache and moves the line as four 32-bit beats over the word-wide memory bus. For reads, it returns the assembled line with a one-cycle replace/finish pulse. For write-backs, it returns a finish pulse only.

---
 rtl/mp_linefill.sv | 156 +++++++++++++++
 tb/tb_mp_linefill.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_linefill.sv
// Memory-side line filler: moves one 128-bit cache line per transaction as four
// linear 32-bit beats on the word bus, returning fills with a replace/finish pulse.
module mp_linefill (
   input  logic         CLK,
   input  logic         sys_rst,
   input  logic         mem_request,
   input  logic         mem_rwn,
   input  logic [15:0]  mem_addr,
   input  logic [127:0] mem_write_data,
   output logic         mem_finish,
   output logic         mem_replace,
   output logic [4:0]   mem_replace_set,
   output logic [6:0]   mem_replace_tag,
   output logic [127:0] mem_read_data,
   output logic         busy,
   output logic         bus_req,
   output logic         bus_we,
   output logic [15:0]  bus_addr,
   output logic [31:0]  bus_wdata,
   input  logic         bus_ack,
   input  logic [31:0]  bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_next;

   logic [1:0]     r_beat;
   logic           r_rwn;
   logic [11:0]    r_line;
   logic [127:0]   r_wdata;
   logic [127:0]   r_rdbuf;
   logic [4:0]     r_rep_set;
   logic [6:0]     r_rep_tag;

   logic           w_active;
   logic           w_start;
   logic           w_xfer;
   logic           w_last;
   logic [6:0]     w_beat_lsb;
   logic           w_unused;

   // Byte offset within the line never reaches the word bus.
   assign w_unused   = ^mem_addr[3:0];

   assign w_active   = (r_state == S_READ) || (r_state == S_WRITE);
   assign w_start    = (r_state == S_IDLE) && mem_request;
   assign w_xfer     = w_active && bus_ack;
   assign w_last     = w_xfer && (r_beat == 2'd3);
   assign w_beat_lsb = {r_beat, 5'd0};

   // State register
   always_ff @(posedge CLK or posedge sys_rst) begin
      if (sys_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (mem_request) begin
               w_next = mem_rwn ? S_READ : S_WRITE;
            end
         end
         S_READ, S_WRITE: begin
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Moore outputs; the bus address/data only leave zero while a beat is active.
   always_comb begin
      busy        = 1'b0;
      bus_req     = 1'b0;
      bus_we      = 1'b0;
      bus_addr    = 16'd0;
      bus_wdata   = 32'd0;
      mem_finish  = 1'b0;
      mem_replace = 1'b0;
      case (r_state)
         S_READ, S_WRITE: begin
            busy      = 1'b1;
            bus_req   = 1'b1;
            bus_we    = ~r_rwn;
            bus_addr  = {r_line, r_beat, 2'b00};
            bus_wdata = r_wdata[w_beat_lsb +: 32];
         end
         S_DONE: begin
            busy        = 1'b1;
            mem_finish  = 1'b1;
            mem_replace = r_rwn;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Request capture and beat sequencing
   always_ff @(posedge CLK or posedge sys_rst) begin
      if (sys_rst) begin
         r_rwn   <= 1'b0;
         r_line  <= 12'd0;
         r_wdata <= 128'd0;
         r_beat  <= 2'd0;
      end else begin
         if (w_start) begin
            r_rwn   <= mem_rwn;
            r_line  <= mem_addr[15:4];
            r_wdata <= mem_write_data;
         end
         if (r_state == S_IDLE) begin
            r_beat <= 2'd0;
         end else if (w_xfer) begin
            r_beat <= r_beat + 2'd1;
         end
      end
   end

   // Fill buffer and replace identifiers; only a READ beat may touch the buffer.
   always_ff @(posedge CLK or posedge sys_rst) begin
      if (sys_rst) begin
         r_rdbuf   <= 128'd0;
         r_rep_set <= 5'd0;
         r_rep_tag <= 7'd0;
      end else begin
         if (w_xfer && (r_state == S_READ)) begin
            r_rdbuf[w_beat_lsb +: 32] <= bus_rdata;
         end
         if (w_last) begin
            r_rep_set <= r_line[4:0];
            r_rep_tag <= r_line[11:5];
         end
      end
   end

   assign mem_read_data   = r_rdbuf;
   assign mem_replace_set = r_rep_set;
   assign mem_replace_tag = r_rep_tag;

endmodule

// File: tb/tb_mp_linefill.sv
// Scoreboard bench for mp_linefill: a word-addressed memory model predicts every
// bus beat and every finish; a wait-state memory responder answers the bus.
module tb_mp_linefill;

   logic         CLK = 1'b0;
   logic         sys_rst;
   logic         mem_request;
   logic         mem_rwn;
   logic [15:0]  mem_addr;
   logic [127:0] mem_write_data;
   logic         mem_finish;
   logic         mem_replace;
   logic [4:0]   mem_replace_set;
   logic [6:0]   mem_replace_tag;
   logic [127:0] mem_read_data;
   logic         busy;
   logic         bus_req;
   logic         bus_we;
   logic [15:0]  bus_addr;
   logic [31:0]  bus_wdata;
   logic         bus_ack;
   logic [31:0]  bus_rdata;

   always #5 CLK = ~CLK;

   mp_linefill dut (
      .CLK            (CLK),
      .sys_rst        (sys_rst),
      .mem_request    (mem_request),
      .mem_rwn        (mem_rwn),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_finish     (mem_finish),
      .mem_replace    (mem_replace),
      .mem_replace_set(mem_replace_set),
      .mem_replace_tag(mem_replace_tag),
      .mem_read_data  (mem_read_data),
      .busy           (busy),
      .bus_req        (bus_req),
      .bus_we         (bus_we),
      .bus_addr       (bus_addr),
      .bus_wdata      (bus_wdata),
      .bus_ack        (bus_ack),
      .bus_rdata      (bus_rdata)
   );

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wd;
      int          cyc;
   } beat_t;

   typedef struct {
      logic         rep;
      logic [4:0]   set;
      logic [6:0]   tag;
      logic [127:0] rd;
      int           cyc;
   } fin_t;

   beat_t        beat_q[$];
   fin_t         fin_q[$];
   int           wait_q[$];
   logic [31:0]  bus_mem[int];
   logic [31:0]  ref_mem[int];
   logic [127:0] last_read;
   int           tests = 0;
   int           fails = 0;
   int           cyc = 0;
   bit           spur = 1'b1;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int a);
      logic [31:0] v;
      v = a;
      return {v[15:0] ^ 16'h5A5A, ~v[15:0]};
   endfunction

   function automatic logic [31:0] bus_rd(input int a);
      return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input int a, input logic [31:0] v);
      bus_mem[a] = v;
      ref_mem[a] = v;
   endtask

   // Memory responder: each beat waits its scheduled number of cycles, then acks.
   // With no request pending it toggles ack/rdata at random, which must be ignored.
   initial begin : responder
      int rem;
      rem = -1;
      bus_ack = 1'b0;
      bus_rdata = 32'd0;
      forever begin
         @(negedge CLK);
         bus_ack = 1'b0;
         bus_rdata = 32'd0;
         if (bus_req) begin
            if (rem < 0) rem = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            if (rem == 0) begin
               bus_ack = 1'b1;
               if (bus_we) bus_mem[int'(bus_addr)] = bus_wdata;
               else bus_rdata = bus_rd(int'(bus_addr));
               rem = -1;
            end else begin
               rem--;
            end
         end else begin
            rem = -1;
            if (spur) begin
               bus_ack = 1'($urandom_range(0, 1));
               bus_rdata = $urandom;
            end
         end
      end
   end

   // Beat monitor: every acked beat against the predicted sequence, plus stability.
   initial begin : beat_mon
      beat_t       e;
      logic        p_req, p_ack, p_we;
      logic [15:0] p_addr;
      logic [31:0] p_wd;
      p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;
      forever begin
         @(negedge CLK);
         #1;
         if (bus_req && p_req && !p_ack) begin
            chk("beat_addr_stable", 128'(bus_addr), 128'(p_addr));
            chk("beat_we_stable", 128'(bus_we), 128'(p_we));
            chk("beat_wdata_stable", 128'(bus_wdata), 128'(p_wd));
         end
         if (bus_req && bus_ack) begin
            if (beat_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got addr %h, expected no beat", bus_addr);
            end else begin
               e = beat_q.pop_front();
               chk("beat_we", 128'(bus_we), 128'(e.we));
               chk("beat_addr", 128'(bus_addr), 128'(e.addr));
               if (e.we) chk("beat_wdata", 128'(bus_wdata), 128'(e.wd));
               chk("beat_cycle", 128'(cyc), 128'(e.cyc));
            end
         end
         p_req = bus_req; p_ack = bus_ack; p_we = bus_we; p_addr = bus_addr; p_wd = bus_wdata;
      end
   end

   // Finish monitor
   initial begin : fin_mon
      fin_t f;
      forever begin
         @(negedge CLK);
         #1;
         if (mem_finish) begin
            if (fin_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_finish: got finish, expected none");
            end else begin
               f = fin_q.pop_front();
               chk("fin_replace", 128'(mem_replace), 128'(f.rep));
               chk("fin_set", 128'(mem_replace_set), 128'(f.set));
               chk("fin_tag", 128'(mem_replace_tag), 128'(f.tag));
               chk("fin_read_data", mem_read_data, f.rd);
               chk("fin_cycle", 128'(cyc), 128'(f.cyc));
            end
         end else if (mem_replace) begin
            chk("replace_without_finish", 128'(mem_replace), 128'(0));
         end
      end
   end

   // Reference model: predicts beats, memory effect and finish for one transaction.
   task automatic issue(input logic rwn, input logic [15:0] addr, input logic [127:0] wd,
                        input int w0, input int w1, input int w2, input int w3, input int t0);
      int           w[4];
      int           t;
      beat_t        b;
      fin_t         f;
      logic [127:0] line;
      logic [15:0]  a;
      w = '{w0, w1, w2, w3};
      t = t0 + 1;
      line = '0;
      for (int i = 0; i < 4; i++) begin
         a = {addr[15:4], 2'(i), 2'b00};
         b.we = ~rwn;
         b.addr = a;
         b.wd = wd[32*i +: 32];
         b.cyc = t + w[i];
         beat_q.push_back(b);
         wait_q.push_back(w[i]);
         t = t + w[i] + 1;
         if (rwn) line[32*i +: 32] = ref_rd(int'(a));
         else ref_mem[int'(a)] = wd[32*i +: 32];
      end
      if (rwn) last_read = line;
      f.rep = rwn;
      f.set = addr[8:4];
      f.tag = addr[15:9];
      f.rd = last_read;
      f.cyc = t;
      fin_q.push_back(f);
      mem_request = 1'b1;
      mem_rwn = rwn;
      mem_addr = addr;
      mem_write_data = wd;
   endtask

   task automatic hard_reset();
      @(negedge CLK);
      #3;
      sys_rst = 1'b1;
      mem_request = 1'b0;
      beat_q.delete();
      fin_q.delete();
      wait_q.delete();
      last_read = '0;
      @(negedge CLK);
      @(negedge CLK);
      #3;
      sys_rst = 1'b0;
   endtask

   // Scrambles the request inputs once latched, then waits for the DONE cycle.
   task automatic run_to_finish(input int t0, input bit keep);
      int n;
      n = 0;
      do @(negedge CLK); while (cyc <= t0);
      mem_addr = 16'($urandom);
      mem_write_data = {$urandom, $urandom, $urandom, $urandom};
      mem_rwn = 1'($urandom);
      while (!mem_finish && n < 300) begin
         @(negedge CLK);
         n++;
      end
      if (!mem_finish) begin
         tests++;
         fails++;
         $display("FAIL finish_timeout: got no finish, expected one within 300 cycles");
         hard_reset();
      end else if (!keep) begin
         mem_request = 1'b0;
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int           t0;
      bit           chained;
      bit           keep;
      logic         rwn;
      logic [15:0]  a;
      logic [127:0] wd;
      logic [127:0] held;
      sys_rst = 1'b1;
      mem_request = 1'b0;
      mem_rwn = 1'b0;
      mem_addr = '0;
      mem_write_data = '0;
      last_read = '0;
      repeat (3) @(negedge CLK);
      #2;
      chk("reset_ctrl", 128'({mem_finish, mem_replace, mem_replace_set, mem_replace_tag, busy,
                              bus_req, bus_we, bus_addr, bus_wdata}), 128'(0));
      chk("reset_read_data", mem_read_data, 128'(0));
      sys_rst = 1'b0;

      // Idle with random acks on the bus
      repeat (4) begin
         @(negedge CLK);
         #2;
         chk("idle_busy", 128'(busy), 128'(0));
         chk("idle_read_data", mem_read_data, 128'(0));
      end

      // Zero-wait read of 0x1230
      for (int i = 0; i < 4; i++) preload(32'h1230 + 4*i, 32'hA0 + i);
      @(negedge CLK);
      t0 = cyc;
      issue(1'b1, 16'h1230, 128'h0, 0, 0, 0, 0, t0);
      run_to_finish(t0, 1'b0);
      chk("read1_latency", 128'(cyc - t0), 128'(5));
      chk("read1_line", mem_read_data, 128'h000000A3_000000A2_000000A1_000000A0);
      chk("read1_set", 128'(mem_replace_set), 128'(5'h03));
      chk("read1_tag", 128'(mem_replace_tag), 128'(7'h09));

      // Acks in DONE and IDLE must not disturb anything
      repeat (3) begin
         @(negedge CLK);
         #2;
         chk("post_done_busy", 128'(busy), 128'(0));
         chk("post_done_data", mem_read_data, 128'h000000A3_000000A2_000000A1_000000A0);
      end

      // Zero-wait write-back of 0x8FF0
      @(negedge CLK);
      t0 = cyc;
      issue(1'b0, 16'h8FF0, 128'h33333333_22222222_11111111_00000000, 0, 0, 0, 0, t0);
      run_to_finish(t0, 1'b0);
      chk("write_keeps_read_data", mem_read_data, 128'h000000A3_000000A2_000000A1_000000A0);

      // Chained write-back then fill, request held across the first finish
      @(negedge CLK);
      t0 = cyc;
      issue(1'b0, 16'h4A50, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0, 0, 0, 0, t0);
      run_to_finish(t0, 1'b1);
      t0 = cyc + 1;
      issue(1'b1, 16'h8FF0, 128'h0, 0, 0, 0, 0, t0);
      run_to_finish(t0, 1'b0);
      chk("chain_fill_data", mem_read_data, 128'h33333333_22222222_11111111_00000000);

      // Three wait states per beat
      @(negedge CLK);
      t0 = cyc;
      issue(1'b1, 16'h4A50, 128'h0, 3, 3, 3, 3, t0);
      run_to_finish(t0, 1'b0);
      chk("wait_latency", 128'(cyc - t0), 128'(17));

      // Reset while beat 2 of a read is waiting
      @(negedge CLK);
      t0 = cyc;
      issue(1'b1, 16'h1230, 128'h0, 0, 0, 3, 0, t0);
      while (cyc < t0 + 4) @(negedge CLK);
      #3;
      sys_rst = 1'b1;
      mem_request = 1'b0;
      #1;
      chk("abort_ctrl", 128'({mem_finish, mem_replace, mem_replace_set, mem_replace_tag, busy,
                              bus_req, bus_we, bus_addr, bus_wdata}), 128'(0));
      chk("abort_read_data", mem_read_data, 128'(0));
      beat_q.delete();
      fin_q.delete();
      wait_q.delete();
      last_read = '0;
      @(negedge CLK);
      @(negedge CLK);
      #3;
      sys_rst = 1'b0;
      @(negedge CLK);
      t0 = cyc;
      issue(1'b1, 16'h1230, 128'h0, 1, 0, 2, 0, t0);
      run_to_finish(t0, 1'b0);

      // Randomized traffic over a small set of lines so reads observe earlier writes
      chained = 1'b0;
      for (int k = 0; k < 40; k++) begin
         keep = (k < 39) && ($urandom_range(0, 2) == 0);
         rwn = 1'($urandom);
         a = {7'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 4'($urandom)};
         wd = {$urandom, $urandom, $urandom, $urandom};
         if (!chained) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            @(negedge CLK);
            t0 = cyc;
         end else begin
            t0 = cyc + 1;
         end
         held = last_read;
         issue(rwn, a, wd, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), t0);
         run_to_finish(t0, keep);
         if (!rwn) chk("rand_write_keeps_data", mem_read_data, held);
         chained = keep;
      end

      repeat (4) @(negedge CLK);
      #2;
      chk("fin_queue_drained", 128'(fin_q.size()), 128'(0));
      chk("beat_queue_drained", 128'(beat_q.size()), 128'(0));
      chk("final_busy", 128'(busy), 128'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
